pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall, branch
// flush, PC-write wait with timeout, and saturating stall/flush event counters.
//
//   state   | meaning
//   RUN     | normal issue; branch flush, PC-write entry and load-use stall resolved here
//   PC_WAIT | PC-writing instruction in flight; Fetch held until it reaches Writeback
module pipeline_hazard_controller #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    RA1D,
  input  logic [3:0]    RA2D,
  input  logic [3:0]    RA1E,
  input  logic [3:0]    RA2E,
  input  logic [3:0]    WA3E,
  input  logic [3:0]    WA3M,
  input  logic [3:0]    WA3W,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          PCSrcD,
  input  logic          PCSrcW,
  input  logic          BranchTakenE,
  input  logic          clear_counters,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic          busy,
  output logic          pc_timeout,
  output logic [CW-1:0] stall_cycles,
  output logic [CW-1:0] flush_cycles
);

  typedef enum logic [0:0] {RUN, PC_WAIT} state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic       timeout_evt;
  logic       ldstall;
  logic       stall_f_c, stall_d_c, flush_d_c, flush_e_c;

  // R15 is the PC and is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (RegWriteM && (WA3M == ra) && (ra != 4'd15))
      return 2'b10;
    else if (RegWriteW && (WA3W == ra) && (ra != 4'd15))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ldstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      cnt        <= 2'd0;
      pc_timeout <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (timeout_evt)
        pc_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    timeout_evt = 1'b0;
    stall_f_c   = 1'b0;
    stall_d_c   = 1'b0;
    flush_d_c   = 1'b0;
    flush_e_c   = 1'b0;
    unique case (state)
      RUN: begin
        if (BranchTakenE) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end else if (PCSrcD) begin
          stall_f_c  = 1'b1;
          flush_d_c  = 1'b1;
          state_next = PC_WAIT;
          cnt_next   = 2'd3;
        end else if (ldstall) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
        end
      end
      PC_WAIT: begin
        flush_d_c = 1'b1;
        stall_f_c = !PCSrcW;
        if (PCSrcW) begin
          state_next = RUN;
        end else if (cnt == 2'd1) begin
          state_next  = RUN;
          timeout_evt = 1'b1;
        end else begin
          cnt_next = cnt - 2'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Combinational outputs are masked so reset takes effect without a clock edge
  assign ForwardAE = reset_n ? fwd_sel(RA1E) : 2'b00;
  assign ForwardBE = reset_n ? fwd_sel(RA2E) : 2'b00;
  assign StallF    = reset_n & stall_f_c;
  assign StallD    = reset_n & stall_d_c;
  assign FlushD    = reset_n & flush_d_c;
  assign FlushE    = reset_n & flush_e_c;
  assign busy      = reset_n & (state == PC_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else if (clear_counters) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (StallF && (stall_cycles != {CW{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      if (FlushE && (flush_cycles != {CW{1'b1}}))
        flush_cycles <= flush_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: forwarding, load-use stall,
// branch flush, PC-write wait/timeout, counter saturation/clear and async reset.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcW, BranchTakenE, clear_counters;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, busy, pc_timeout;
  logic [15:0] stall_cycles, flush_cycles;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller dut (
    .clk(clk), .reset_n(reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .clear_counters(clear_counters),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .busy(busy), .pc_timeout(pc_timeout),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic en);
    MemtoRegE = en;
    WA3E      = 4'd3;
    RA2D      = en ? 4'd3 : 4'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcW, BranchTakenE, clear_counters} = '0;
    RA1D = 4'd9;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stallf", StallF, 0);
    chk("rst_flushe", FlushE, 0);
    chk("rst_fwda", ForwardAE, 0);
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_timeout", pc_timeout, 0);
    tick(); tick();
    #3 reset_n = 1'b1;

    // Forwarding
    tick();
    RegWriteM = 1; WA3M = 4; RegWriteW = 1; WA3W = 4; RA1E = 4; RA2E = 4;
    #1;
    chk("fwd_a_mem_prio", ForwardAE, 2'b10);
    chk("fwd_b_mem_prio", ForwardBE, 2'b10);
    RA1E = 15; #1;
    chk("fwd_a_r15", ForwardAE, 2'b00);
    RegWriteM = 0; RA1E = 4; #1;
    chk("fwd_a_wb", ForwardAE, 2'b01);
    RegWriteM = 1; WA3W = 5; RA2E = 5; #1;
    chk("fwd_b_wb", ForwardBE, 2'b01);
    RegWriteW = 0; #1;
    chk("fwd_b_none", ForwardBE, 2'b00);
    {RegWriteM, RegWriteW, WA3M, WA3W, RA1E, RA2E} = '0;

    // Load-use stall on RA2D, then on RA1D
    set_load_use(1); #1;
    chk("ld_stallf", StallF, 1);
    chk("ld_stalld", StallD, 1);
    chk("ld_flushe", FlushE, 1);
    chk("ld_flushd", FlushD, 0);
    tick();
    set_load_use(0); #1;
    chk("ld_stallf_off", StallF, 0);
    chk("ld_stall_cnt", stall_cycles, 1);
    chk("ld_flush_cnt", flush_cycles, 1);
    MemtoRegE = 1; WA3E = 7; RA1D = 7; #1;
    chk("ld_ra1d_stalld", StallD, 1);
    tick();
    MemtoRegE = 0; RA1D = 9; #1;
    chk("ld2_stall_cnt", stall_cycles, 2);
    chk("ld2_flush_cnt", flush_cycles, 2);

    // Clear beats simultaneous increment
    set_load_use(1); clear_counters = 1;
    tick();
    set_load_use(0); clear_counters = 0; #1;
    chk("clr_stall_cnt", stall_cycles, 0);
    chk("clr_flush_cnt", flush_cycles, 0);

    // Branch overrides PCSrcD and ldstall
    BranchTakenE = 1; PCSrcD = 1; set_load_use(1); #1;
    chk("br_flushd", FlushD, 1);
    chk("br_flushe", FlushE, 1);
    chk("br_stallf", StallF, 0);
    chk("br_stalld", StallD, 0);
    tick();
    BranchTakenE = 0; PCSrcD = 0; set_load_use(0); #1;
    chk("br_busy", busy, 0);
    chk("br_flush_cnt", flush_cycles, 1);
    chk("br_stall_cnt", stall_cycles, 0);

    // PC write completing via PCSrcW three cycles later
    clear_counters = 1; tick(); clear_counters = 0;
    PCSrcD = 1; #1;
    chk("pc0_stallf", StallF, 1);
    chk("pc0_flushd", FlushD, 1);
    chk("pc0_busy", busy, 0);
    tick();
    PCSrcD = 0; #1;
    chk("pc1_stallf", StallF, 1);
    chk("pc1_flushd", FlushD, 1);
    chk("pc1_busy", busy, 1);
    tick();
    set_load_use(1); BranchTakenE = 1; #1;
    chk("pc2_stallf", StallF, 1);
    chk("pc2_flushd", FlushD, 1);
    chk("pc2_busy", busy, 1);
    chk("pc2_ign_stalld", StallD, 0);
    chk("pc2_ign_flushe", FlushE, 0);
    tick();
    set_load_use(0); BranchTakenE = 0; PCSrcW = 1; #1;
    chk("pc3_stallf", StallF, 0);
    chk("pc3_flushd", FlushD, 1);
    chk("pc3_busy", busy, 1);
    tick();
    PCSrcW = 0; #1;
    chk("pc4_busy", busy, 0);
    chk("pc4_flushd", FlushD, 0);
    chk("pc4_timeout", pc_timeout, 0);
    chk("pc_stall_cnt", stall_cycles, 3);
    chk("pc_flush_cnt", flush_cycles, 0);

    // Timeout: PCSrcW never arrives
    PCSrcD = 1;
    tick();
    PCSrcD = 0; #1;
    chk("to1_busy", busy, 1);
    chk("to1_timeout", pc_timeout, 0);
    tick(); chk("to2_busy", busy, 1);
    tick(); chk("to3_busy", busy, 1);
    chk("to3_timeout", pc_timeout, 0);
    tick();
    chk("to4_busy", busy, 0);
    chk("to4_timeout", pc_timeout, 1);
    tick(); tick();
    chk("to_sticky", pc_timeout, 1);

    // Saturation of both counters under a held load-use condition
    clear_counters = 1; tick(); clear_counters = 0;
    set_load_use(1);
    repeat (65535) tick();
    chk("sat_stall_reach", stall_cycles, 16'hFFFF);
    chk("sat_flush_reach", flush_cycles, 16'hFFFF);
    repeat (3) tick();
    chk("sat_stall_hold", stall_cycles, 16'hFFFF);
    chk("sat_flush_hold", flush_cycles, 16'hFFFF);
    set_load_use(0);

    // Async reset mid-PC_WAIT
    PCSrcD = 1;
    tick();
    PCSrcD = 0;
    RegWriteM = 1; WA3M = 6; RA1E = 6; #1;
    chk("mid_busy_pre", busy, 1);
    chk("mid_fwd_pre", ForwardAE, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stallf", StallF, 0);
    chk("arst_flushd", FlushD, 0);
    chk("arst_fwda", ForwardAE, 2'b00);
    chk("arst_timeout", pc_timeout, 0);
    chk("arst_stall_cnt", stall_cycles, 0);
    chk("arst_flush_cnt", flush_cycles, 0);
    tick();
    #3 reset_n = 1'b1;
    RegWriteM = 0; WA3M = 0; RA1E = 0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_stallf", StallF, 0);
    chk("post_rst_flushd", FlushD, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
